// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: sequential signed-decimal / hex driver for active-low
// multi-digit 7-segment displays, converting by iterative double dabble.
//
// Ports:
//   clk, resetn         clock, async active-low reset
//   wr_en, wr_data      one-cycle write strobe and value
//   mode_hex            sampled with wr_en: 1 = raw hex, 0 = signed decimal
//   busy                conversion running or write pending
//   done                one-cycle pulse when seg/sign_seg update
//   seg                 digit i at [7i+6:7i], bit0 = a .. bit6 = g, 0 = lit
//   sign_seg            minus-sign digit (g only when negative)
//   dot                 decimal point, always off
//
// Optional feature: define SEG_LZ_BLANK_EN to blank decimal leading zeros.

module seg_display_ctrl #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  mode_hex,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            sign_seg,
    output logic                  dot
);

    localparam int HEXD = (DATA_W + 3) / 4;
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

    state_e                state_q;
    logic [BW-1:0]         bcd_q;
    logic [DATA_W-1:0]     mag_q;
    logic [CW-1:0]         cnt_q;
    logic                  neg_q;
    logic                  hex_q;
    logic                  pend_vld_q;
    logic [DATA_W-1:0]     pend_data_q;
    logic                  pend_hex_q;
    logic [7*DIGITS-1:0]   seg_q;
    logic [6:0]            sign_q;
    logic                  done_q;

    logic                  launch;
    logic [DATA_W-1:0]     l_data;
    logic                  l_hex;
    logic [DATA_W-1:0]     l_mag;
    logic [BW-1:0]         bcd_adj;
    logic [BW-1:0]         bcd_sh;
    logic [DATA_W-1:0]     mag_sh;
    logic [7*DIGITS-1:0]   seg_d;
    logic                  allz;
    logic                  blank;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'h0: seg_enc = 7'b1000000;
            4'h1: seg_enc = 7'b1111001;
            4'h2: seg_enc = 7'b0100100;
            4'h3: seg_enc = 7'b0110000;
            4'h4: seg_enc = 7'b0011001;
            4'h5: seg_enc = 7'b0010010;
            4'h6: seg_enc = 7'b0000010;
            4'h7: seg_enc = 7'b1111000;
            4'h8: seg_enc = 7'b0000000;
            4'h9: seg_enc = 7'b0010000;
            4'hA: seg_enc = 7'b0001000;
            4'hB: seg_enc = 7'b0000011;
            4'hC: seg_enc = 7'b1000110;
            4'hD: seg_enc = 7'b0100001;
            4'hE: seg_enc = 7'b0000110;
            default: seg_enc = 7'b0001110;
        endcase
    endfunction

    // A live write always beats the pending entry, which is then dropped.
    always_comb begin
        launch = (state_q == IDLE) && (wr_en || pend_vld_q);
        l_data = wr_en ? wr_data  : pend_data_q;
        l_hex  = wr_en ? mode_hex : pend_hex_q;
        // Unsigned magnitude keeps the most negative value exact.
        l_mag  = l_data[DATA_W-1]
               ? (~l_data + {{(DATA_W-1){1'b0}}, 1'b1})
               : l_data;
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_sh, mag_sh} = {bcd_adj, mag_q} << 1;
    end

    // Digit encoding; scanned from the top so allz marks leading zeros.
    always_comb begin
        seg_d = '1;
        allz  = 1'b1;
        blank = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allz  = allz && (bcd_q[4*i +: 4] == 4'd0);
            blank = hex_q && (i >= HEXD);
`ifdef SEG_LZ_BLANK_EN
            if (!hex_q && (i != 0) && allz)
                blank = 1'b1;
`endif
            seg_d[7*i +: 7] = blank ? 7'b1111111 : seg_enc(bcd_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            hex_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_hex_q  <= 1'b0;
            seg_q       <= '1;
            sign_q      <= 7'b1111111;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        pend_vld_q <= 1'b0;
                        hex_q      <= l_hex;
                        cnt_q      <= '0;
                        if (l_hex) begin
                            bcd_q             <= '0;
                            bcd_q[DATA_W-1:0] <= l_data;
                            neg_q             <= 1'b0;
                            state_q           <= LOAD;
                        end else begin
                            bcd_q   <= '0;
                            mag_q   <= l_mag;
                            neg_q   <= l_data[DATA_W-1];
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_q <= bcd_sh;
                    mag_q <= mag_sh;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1))
                        state_q <= LOAD;
                end
                LOAD: begin
                    seg_q   <= seg_d;
                    sign_q  <= neg_q ? 7'b0111111 : 7'b1111111;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (wr_en && (state_q != IDLE)) begin
                pend_vld_q  <= 1'b1;
                pend_data_q <= wr_data;
                pend_hex_q  <= mode_hex;
            end
        end
    end

    assign busy     = (state_q != IDLE) || pend_vld_q;
    assign done     = done_q;
    assign seg      = seg_q;
    assign sign_seg = sign_q;
    assign dot      = 1'b1;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: randomized self-checking bench for seg_display_ctrl
// against an arithmetic (divide/modulo) reference model.

module tb_seg_display_ctrl;

    localparam int DW = 32;
    localparam int ND = 10;
    localparam int HD = (DW + 3) / 4;

    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic            clk = 1'b0;
    logic            resetn;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            mode_hex;
    logic            busy;
    logic            done;
    logic [7*ND-1:0] seg;
    logic [6:0]      sign_seg;
    logic            dot;

    int total = 0;
    int bad   = 0;

    logic [7*ND-1:0] dseg_q [$];
    logic [6:0]      dsgn_q [$];

    seg_display_ctrl #(.DATA_W(DW), .DIGITS(ND)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .mode_hex (mode_hex),
        .busy     (busy),
        .done     (done),
        .seg      (seg),
        .sign_seg (sign_seg),
        .dot      (dot)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            dseg_q.push_back(seg);
            dsgn_q.push_back(sign_seg);
        end
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7*ND-1:0] model_seg(input logic [DW-1:0] v,
                                                  input bit hex);
        logic [7*ND-1:0] r;
        longint unsigned m;
        int dg [ND];
        int hi;
        r = '1;
        if (hex) begin
            for (int i = 0; i < ND; i++)
                r[7*i +: 7] = (i < HD) ? PAT[(v >> (4*i)) & 'hF] : 7'h7F;
        end else begin
            m  = v[DW-1] ? ((64'd1 << DW) - 64'(v)) : 64'(v);
            hi = 0;
            for (int i = 0; i < ND; i++) begin
                dg[i] = int'(m % 10);
                m     = m / 10;
                if (dg[i] != 0) hi = i;
            end
            for (int i = 0; i < ND; i++) begin
                r[7*i +: 7] = PAT[dg[i]];
`ifdef SEG_LZ_BLANK_EN
                if (i > hi) r[7*i +: 7] = 7'h7F;
`endif
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] model_sign(input logic [DW-1:0] v,
                                              input bit hex);
        return (!hex && v[DW-1]) ? 7'b0111111 : 7'b1111111;
    endfunction

    task automatic do_write(input logic [DW-1:0] v, input bit hex);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_data  = v;
        mode_hex = hex;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    task automatic single(input string tag, input logic [DW-1:0] v,
                          input bit hex);
        int n;
        do_write(v, hex);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 128'(n), hex ? 128'(1) : 128'(DW + 1));
        check({tag, "_seg"}, 128'(seg), 128'(model_seg(v, hex)));
        check({tag, "_sgn"}, 128'(sign_seg), 128'(model_sign(v, hex)));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        @(negedge clk);
        check({tag, "_pulse"}, 128'(done), 128'(0));
    endtask

    // First write is decimal; x1 then x2 arrive while it converts.
    task automatic burst(input string tag, input logic [DW-1:0] a,
                         input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                         input bit lh);
        int s0, nd, t1, t2, bl;
        s0 = dseg_q.size();
        nd = 0; t1 = 0; t2 = 0; bl = 0;
        do_write(a, 1'b0);
        for (int c = 1; c <= 90; c++) begin
            wr_en    = (c == 3) || (c == 6);
            wr_data  = (c == 6) ? x2 : x1;
            mode_hex = (c == 6) ? lh : 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) t1 = c;
                else t2 = c;
            end
            if (nd < 2 && busy !== 1'b1) bl++;
        end
        wr_en = 1'b0;
        check({tag, "_ndone"}, 128'(dseg_q.size() - s0), 128'(2));
        check({tag, "_t1"}, 128'(t1), 128'(DW + 1));
        check({tag, "_t2"}, 128'(t2), lh ? 128'(DW + 3) : 128'(2*DW + 3));
        check({tag, "_busylow"}, 128'(bl), 128'(0));
        check({tag, "_idle"}, 128'(busy), 128'(0));
        if (dseg_q.size() >= s0 + 2) begin
            check({tag, "_seg1"}, 128'(dseg_q[s0]), 128'(model_seg(a, 1'b0)));
            check({tag, "_sgn1"}, 128'(dsgn_q[s0]), 128'(model_sign(a, 1'b0)));
            check({tag, "_seg2"}, 128'(dseg_q[s0+1]), 128'(model_seg(x2, lh)));
            check({tag, "_sgn2"}, 128'(dsgn_q[s0+1]), 128'(model_sign(x2, lh)));
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        bit            h;
        int            s0;

        resetn   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        mode_hex = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", 128'(seg), 128'({7*ND{1'b1}}));
        check("rst_sgn", 128'(sign_seg), 128'(7'h7F));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_dot", 128'(dot), 128'(1));
        resetn = 1'b1;
        @(negedge clk);

        single("d12345", 32'd12345, 1'b0);
        single("dm1", 32'hFFFF_FFFF, 1'b0);
        single("dmin", 32'h8000_0000, 1'b0);
        single("hdead", 32'hDEAD_BEEF, 1'b1);
        single("dzero", 32'd0, 1'b0);
        single("dmax", 32'h7FFF_FFFF, 1'b0);
        single("hzero", 32'd0, 1'b1);

        // Reset mid-conversion after a displayed value.
        s0 = dseg_q.size();
        do_write(32'd999, 1'b0);
        repeat (10) @(negedge clk);
        check("mid_busy", 128'(busy), 128'(1));
        #2 resetn = 1'b0;
        #1;
        check("mid_seg", 128'(seg), 128'({7*ND{1'b1}}));
        check("mid_sgn", 128'(sign_seg), 128'(7'h7F));
        check("mid_busy0", 128'(busy), 128'(0));
        check("mid_done", 128'(done), 128'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_nodone", 128'(dseg_q.size() - s0), 128'(0));
        check("mid_hold", 128'(seg), 128'({7*ND{1'b1}}));

        burst("pend789", 32'd7, 32'd8, 32'd9, 1'b0);

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 7))
                0: v = 32'h8000_0000;
                1: v = 32'hFFFF_FFFF;
                2: v = 32'd0;
                3: v = $urandom_range(0, 99);
                default: v = $urandom;
            endcase
            h = 1'($urandom_range(0, 1));
            single($sformatf("rnd%0d", k), v, h);
        end

        for (int k = 0; k < 4; k++) begin
            burst($sformatf("rburst%0d", k), $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
